ps2_keymap: RTL
===============

// Module: ps2_keymap
// PURPOSE
//  PS/2 set-2 scan-code to Hack keycode translator with modifier tracking and an output FIFO.
//  Sits between the PS/2 receiver (scan_code/scan_ready) and the Hack keyboard memory map / CPU I/O.
//  Handles E0/F0 prefixes, shift/caps-lock case mapping and extended nav keys.
//  Emits one keycode per make event over a valid/ready stream.
// PARAMETERS
//  FIFO_DEPTH  8  output FIFO entries; power of two, >=2
//  CODE_W      8  keycode width; >=8, upper bits zero-filled
// PORTS
//  clk         in   1             system clock, all logic on posedge
//  rst_n       in   1             asynchronous active-low reset
//  scan_ready  in   1             one-cycle strobe, scan_code valid
//  scan_code   in   8             received PS/2 byte
//  out_valid   out  1             FIFO non-empty
//  out_code    out  CODE_W        head-of-FIFO keycode (first-word fall-through)
//  out_ready   in   1             consumer pops when out_valid&out_ready
//  overflow    out  1             one-cycle pulse: keycode dropped, FIFO full
//  mods        out  3             {caps_lock, ctrl, shift} current state
//  key_held    out  CODE_W        keycode of key currently down (see CONFIGURATION)
// BEHAVIOUR
//  Reset: out_valid=0, out_code=0, overflow=0, mods=0, key_held=0, FIFO empty, FSM=IDLE.
//  Decode FSM advances only on scan_ready: IDLE -E0-> EXT; IDLE -F0-> BRK; EXT -F0-> EXT_BRK;
//   other bytes complete an event and return to IDLE. E0 in BRK, or any E0/F0 in EXT_BRK -> IDLE, byte dropped.
//  Modifiers: 12/59 shift (either held => shift=1); 14 and E0 14 ctrl; make sets, break clears.
//   58 caps: toggles on make only if caps key not already down (typematic repeat ignored).
//   Modifier events never push keycodes.
//  Make event (non-modifier): keycode from lookup; zero => nothing pushed.
//   Letters: 97-122; 65-90 when shift XOR caps_lock.
//   Digits/punct: unshifted ASCII; with shift the US shifted glyph (1->'!', '-'->'_', '/'->'?' etc).
//   Keypad digits/./*/+/- fixed ASCII, shift ignored. Enter 128, Backspace 129, Esc 140, F1-F12 141-152.
//   Extended: L/U/R/D arrow 130-133, Home 134, End 135, PgUp 136, PgDn 137, Ins 138, Del 139,
//   KP Enter 128, KP / 47. Unmapped codes -> 0.
//  Break events push nothing. Typematic repeats push a keycode per make.
//  Latency: final byte sampled at edge N -> registered lookup at N -> FIFO write at N+1;
//   out_valid high after N+1 when FIFO was empty.
//  FIFO: full and no pop in the write cycle -> keycode dropped, overflow pulses 1 cycle, contents intact.
//   Simultaneous push+pop when full -> both accepted, count unchanged. Pop on empty ignored.
//   Pointers wrap modulo FIFO_DEPTH.
//  rst_n asserted mid-sequence (after E0/F0) -> FSM, modifiers and FIFO cleared immediately; partial sequence lost.
// CONFIGURATION
//  KEYMAP_HOLD_EN defined: key_held = keycode of most recent make (incl. 0 if unmapped).
//   Cleared to 0 only by the break of that same key (code and E0 flag both match);
//   other keys' breaks leave it. Gives Hack memory-map "held key" semantics.
//  Undefined: key_held tied to 0; no hold register synthesised.
// STRUCTURE
//  Package ps2_keymap_pkg: scan-code constants (SC_EXT=E0, SC_BRK=F0, SC_LSHIFT, SC_RSHIFT,
//   SC_CTRL, SC_CAPS), Hack keycode constants (HK_ENTER=128 ... HK_F12=152), FSM state enum.
//  Sub-module ps2_keymap_fifo: sync FWFT FIFO (DEPTH, WIDTH, push/pop/full/empty).
//  Lookup tables as case functions in the top module.
// TESTING
//  1C -> code 97; 12,1C,F0 1C,F0 12 -> 65 only; mods.shift 1 then 0.
//  58,F0 58,1C -> 65; 58,58(repeat),F0 58,1C -> 65 (caps stays 1).
//  E0 75 -> 131; E0 F0 75 -> nothing; 75 alone -> 56 (KP 8).
//  out_ready=0, 9x 1C, FIFO_DEPTH=8 -> 8 entries, overflow pulses once; drain yields 8x 97.
//  FIFO full, push with simultaneous pop same cycle -> both accepted, no overflow, count stays 8.
//  E0 then rst_n low 1 cycle, then 75 -> 56 (prefix lost); with KEYMAP_HOLD_EN: 1C -> key_held 97,
//   F0 32 -> key_held 97, F0 1C -> key_held 0.

Source files
------------

// File: rtl/ps2_keymap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keymap_pkg
//  Description : Shared constants for the PS/2 set-2 to Hack keycode
//                translator: scan-code bytes, Hack keycodes, decode states.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_keymap_pkg;

    // PS/2 set-2 scan codes with special meaning to the decoder
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Hack platform keycodes for non-printing keys
    localparam logic [7:0] HK_ENTER     = 8'd128;
    localparam logic [7:0] HK_BACKSPACE = 8'd129;
    localparam logic [7:0] HK_LEFT      = 8'd130;
    localparam logic [7:0] HK_UP        = 8'd131;
    localparam logic [7:0] HK_RIGHT     = 8'd132;
    localparam logic [7:0] HK_DOWN      = 8'd133;
    localparam logic [7:0] HK_HOME      = 8'd134;
    localparam logic [7:0] HK_END       = 8'd135;
    localparam logic [7:0] HK_PGUP      = 8'd136;
    localparam logic [7:0] HK_PGDN      = 8'd137;
    localparam logic [7:0] HK_INSERT    = 8'd138;
    localparam logic [7:0] HK_DELETE    = 8'd139;
    localparam logic [7:0] HK_ESC       = 8'd140;
    localparam logic [7:0] HK_F1        = 8'd141;
    localparam logic [7:0] HK_F12       = 8'd152;

    // Prefix-tracking decoder states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_keymap_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keymap_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                presented on dout whenever the FIFO is non-empty (zero when
//                empty). A push while full is accepted only if a pop happens
//                in the same cycle; a pop while empty is ignored.
//  Ports       : clk, rst_n (async active-low), push/din, pop/dout,
//                full, empty
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_keymap_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot being written.
    assign w_push = push & (~full | w_pop);
    assign dout   = empty ? '0 : r_mem[r_rd_ptr];

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keymap
//  Description : PS/2 set-2 scan-code to Hack keycode translator. Tracks the
//                E0/F0 prefixes, shift/ctrl/caps-lock, maps make events to
//                Hack keycodes and queues them in an output FIFO.
//  Ports       : clk, rst_n (async active-low)
//                scan_ready/scan_code  byte strobe from the PS/2 receiver
//                out_valid/out_code/out_ready  keycode stream (FWFT)
//                overflow  one-cycle pulse when a keycode is dropped
//                mods      {caps_lock, ctrl, shift}
//                key_held  keycode of the key currently down
//  Options     : KEYMAP_HOLD_EN  enables the held-key register; when
//                undefined key_held is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_keymap
    import ps2_keymap_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CODE_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_ready,
    input  logic [7:0]        scan_code,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    input  logic              out_ready,
    output logic              overflow,
    output logic [2:0]        mods,
    output logic [CODE_W-1:0] key_held
);

    // ---------------- lookup tables ----------------
    // Letters return lower case; case conversion is applied by the caller.
    function automatic logic [7:0] f_letter(input logic [7:0] sc);
        logic [7:0] k;
        k = 8'd0;
        case (sc)
            8'h1C: k = "a";  8'h32: k = "b";  8'h21: k = "c";  8'h23: k = "d";
            8'h24: k = "e";  8'h2B: k = "f";  8'h34: k = "g";  8'h33: k = "h";
            8'h43: k = "i";  8'h3B: k = "j";  8'h42: k = "k";  8'h4B: k = "l";
            8'h3A: k = "m";  8'h31: k = "n";  8'h44: k = "o";  8'h4D: k = "p";
            8'h15: k = "q";  8'h2D: k = "r";  8'h1B: k = "s";  8'h2C: k = "t";
            8'h3C: k = "u";  8'h2A: k = "v";  8'h1D: k = "w";  8'h22: k = "x";
            8'h35: k = "y";  8'h1A: k = "z";
            default: k = 8'd0;
        endcase
        return k;
    endfunction

    // Digits, punctuation, keypad and function keys (non-extended codes).
    function automatic logic [7:0] f_main(input logic [7:0] sc, input logic shift);
        logic [7:0] k;
        k = 8'd0;
        case (sc)
            8'h16: k = shift ? "!"  : "1";
            8'h1E: k = shift ? "@"  : "2";
            8'h26: k = shift ? "#"  : "3";
            8'h25: k = shift ? "$"  : "4";
            8'h2E: k = shift ? "%"  : "5";
            8'h36: k = shift ? "^"  : "6";
            8'h3D: k = shift ? "&"  : "7";
            8'h3E: k = shift ? "*"  : "8";
            8'h46: k = shift ? "("  : "9";
            8'h45: k = shift ? ")"  : "0";
            8'h0E: k = shift ? "~"  : 8'h60;
            8'h4E: k = shift ? "_"  : "-";
            8'h55: k = shift ? "+"  : "=";
            8'h54: k = shift ? "{"  : "[";
            8'h5B: k = shift ? "}"  : "]";
            8'h5D: k = shift ? "|"  : "\\";
            8'h4C: k = shift ? ":"  : ";";
            8'h52: k = shift ? "\"" : "'";
            8'h41: k = shift ? "<"  : ",";
            8'h49: k = shift ? ">"  : ".";
            8'h4A: k = shift ? "?"  : "/";
            8'h29: k = " ";
            // keypad: fixed glyphs regardless of shift
            8'h70: k = "0";  8'h69: k = "1";  8'h72: k = "2";  8'h7A: k = "3";
            8'h6B: k = "4";  8'h73: k = "5";  8'h74: k = "6";  8'h6C: k = "7";
            8'h75: k = "8";  8'h7D: k = "9";  8'h71: k = ".";  8'h7C: k = "*";
            8'h79: k = "+";  8'h7B: k = "-";
            8'h5A: k = HK_ENTER;
            8'h66: k = HK_BACKSPACE;
            8'h76: k = HK_ESC;
            // function keys have scattered set-2 codes
            8'h05: k = HK_F1;
            8'h06: k = HK_F1 + 8'd1;
            8'h04: k = HK_F1 + 8'd2;
            8'h0C: k = HK_F1 + 8'd3;
            8'h03: k = HK_F1 + 8'd4;
            8'h0B: k = HK_F1 + 8'd5;
            8'h83: k = HK_F1 + 8'd6;
            8'h0A: k = HK_F1 + 8'd7;
            8'h01: k = HK_F1 + 8'd8;
            8'h09: k = HK_F1 + 8'd9;
            8'h78: k = HK_F1 + 8'd10;
            8'h07: k = HK_F12;
            default: k = 8'd0;
        endcase
        return k;
    endfunction

    // E0-prefixed navigation keys.
    function automatic logic [7:0] f_ext(input logic [7:0] sc);
        logic [7:0] k;
        k = 8'd0;
        case (sc)
            8'h6B: k = HK_LEFT;    8'h75: k = HK_UP;
            8'h74: k = HK_RIGHT;   8'h72: k = HK_DOWN;
            8'h6C: k = HK_HOME;    8'h69: k = HK_END;
            8'h7D: k = HK_PGUP;    8'h7A: k = HK_PGDN;
            8'h70: k = HK_INSERT;  8'h71: k = HK_DELETE;
            8'h5A: k = HK_ENTER;   8'h4A: k = "/";
            default: k = 8'd0;
        endcase
        return k;
    endfunction

    // ---------------- prefix decoder ----------------
    kb_state_t r_state;
    kb_state_t w_next_state;
    logic      w_ev_valid;
    logic      w_ev_brk;
    logic      w_ev_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_ev_valid   = 1'b0;
        w_ev_brk     = 1'b0;
        w_ev_ext     = 1'b0;
        if (scan_ready) begin
            case (r_state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)      w_next_state = ST_EXT;
                    else if (scan_code == SC_BRK) w_next_state = ST_BRK;
                    else                          w_ev_valid   = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == SC_BRK) begin
                        w_next_state = ST_EXT_BRK;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_ev_valid   = 1'b1;
                        w_ev_ext     = 1'b1;
                    end
                end
                ST_BRK: begin
                    // "F0 E0" is malformed: abandon the sequence.
                    w_next_state = ST_IDLE;
                    w_ev_valid   = (scan_code != SC_EXT);
                    w_ev_brk     = 1'b1;
                end
                ST_EXT_BRK: begin
                    w_next_state = ST_IDLE;
                    w_ev_valid   = (scan_code != SC_EXT) && (scan_code != SC_BRK);
                    w_ev_brk     = 1'b1;
                    w_ev_ext     = 1'b1;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // ---------------- modifiers and keycode mapping ----------------
    logic       r_lshift, r_rshift, r_ctrl, r_caps_lock, r_caps_down;
    logic       r_push_valid;
    logic [7:0] r_push_code;
    logic       w_shift;
    logic       w_is_shift, w_is_ctrl, w_is_caps, w_is_mod;
    logic [7:0] w_letter;
    logic [7:0] w_key;

    assign w_shift    = r_lshift | r_rshift;
    assign w_is_shift = !w_ev_ext && (scan_code == SC_LSHIFT || scan_code == SC_RSHIFT);
    assign w_is_ctrl  = (scan_code == SC_CTRL);
    assign w_is_caps  = !w_ev_ext && (scan_code == SC_CAPS);
    assign w_is_mod   = w_is_shift | w_is_ctrl | w_is_caps;
    assign w_letter   = f_letter(scan_code);

    always_comb begin
        w_key = 8'd0;
        if (w_ev_ext)
            w_key = f_ext(scan_code);
        else if (w_letter != 8'd0)
            w_key = (w_shift ^ r_caps_lock) ? (w_letter - 8'd32) : w_letter;
        else
            w_key = f_main(scan_code, w_shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lshift     <= 1'b0;
            r_rshift     <= 1'b0;
            r_ctrl       <= 1'b0;
            r_caps_lock  <= 1'b0;
            r_caps_down  <= 1'b0;
            r_push_valid <= 1'b0;
            r_push_code  <= 8'd0;
        end else begin
            r_push_valid <= 1'b0;
            if (w_ev_valid) begin
                if (w_is_shift) begin
                    if (scan_code == SC_LSHIFT) r_lshift <= !w_ev_brk;
                    else                        r_rshift <= !w_ev_brk;
                end else if (w_is_ctrl) begin
                    r_ctrl <= !w_ev_brk;
                end else if (w_is_caps) begin
                    // Typematic repeats of the caps key must not re-toggle.
                    if (w_ev_brk) begin
                        r_caps_down <= 1'b0;
                    end else begin
                        if (!r_caps_down) r_caps_lock <= ~r_caps_lock;
                        r_caps_down <= 1'b1;
                    end
                end else if (!w_ev_brk) begin
                    r_push_valid <= (w_key != 8'd0);
                    r_push_code  <= w_key;
                end
            end
        end
    end

    assign mods = {r_caps_lock, r_ctrl, w_shift};

    // ---------------- output FIFO ----------------
    logic w_full;
    logic w_empty;

    ps2_keymap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_push_valid),
        .din   (CODE_W'(r_push_code)),
        .pop   (out_ready),
        .dout  (out_code),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid = ~w_empty;
    // Mirrors the FIFO's own drop condition.
    assign overflow  = r_push_valid & w_full & ~(out_valid & out_ready);

    // ---------------- held key ----------------
`ifdef KEYMAP_HOLD_EN
    logic [7:0] r_held_code;
    logic [7:0] r_held_sc;
    logic       r_held_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held_code <= 8'd0;
            r_held_sc   <= 8'd0;
            r_held_ext  <= 1'b0;
        end else if (w_ev_valid && !w_is_mod) begin
            if (!w_ev_brk) begin
                r_held_code <= w_key;
                r_held_sc   <= scan_code;
                r_held_ext  <= w_ev_ext;
            end else if (scan_code == r_held_sc && w_ev_ext == r_held_ext) begin
                r_held_code <= 8'd0;
            end
        end
    end

    assign key_held = CODE_W'(r_held_code);
`else
    assign key_held = '0;
`endif

endmodule
`default_nettype wire
